llc_rst_flush_seq: RTL and testbench

Sequencer that drives the LLC's reset and flush walks. It is the producer side of the stall/set-counter handshake held in the LLC register bank. On reset it invalidates every set. On a flush request it reads each set, writes back dirty lines through a valid/ready channel, and rewrites line state. It then releases `rst_stall` / `flush_stall` and pulses `done`.

---
 rtl/llc_rst_flush_seq_pkg.sv | 14 +
 rtl/llc_set_walker.sv | 38 +++
 rtl/llc_rst_flush_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_llc_rst_flush_seq.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_rst_flush_seq_pkg.sv
// Shared LLC cache types and default geometry used by the reset/flush sequencer.
package llc_rst_flush_seq_pkg;

  localparam int LLC_SET_BITS = 8;
  localparam int LLC_WAYS     = 16;
  localparam int LLC_WAY_BITS = $clog2(LLC_WAYS);
  localparam int LLC_TAG_BITS = 14;

  typedef logic [LLC_SET_BITS-1:0]              llc_set_t;
  typedef logic [LLC_WAY_BITS-1:0]              llc_way_t;
  typedef logic [LLC_TAG_BITS-1:0]              llc_tag_t;
  typedef logic [LLC_TAG_BITS+LLC_SET_BITS-1:0] line_addr_t;

endpackage

// File: rtl/llc_set_walker.sv
// Set index counter shared by the reset and flush walks: clear, increment, last-set flag.
module llc_set_walker #(
  parameter int SET_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [SET_BITS-1:0] set_o,
  output logic                last_o
);

  logic [SET_BITS-1:0] set_q;
  logic [SET_BITS-1:0] set_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    set_d = set_q;
    if (clr) begin
      set_d = '0;
    end else if (inc) begin
      set_d = set_q + SET_BITS'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_q <= '0;
    end else begin
      set_q <= set_d;
    end
  end

  assign set_o  = set_q;
  assign last_o = &set_q;

endmodule

// File: rtl/llc_rst_flush_seq.sv
// LLC reset/flush sequencer: invalidates every set after reset and walks all sets on a
// flush request, writing back dirty lines through a valid/ready channel.
module llc_rst_flush_seq
  import llc_rst_flush_seq_pkg::*;
#(
  parameter int  SET_BITS = LLC_SET_BITS,
  parameter int  WAYS     = LLC_WAYS,
  parameter int  TAG_BITS = LLC_TAG_BITS,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rst_req,
  input  logic                         flush_req,
  input  logic                         flush_all,
  output logic                         rst_wr_en,
  output logic [SET_BITS-1:0]          rst_wr_set,
  output logic                         rd_set_en,
  output logic [SET_BITS-1:0]          rd_set,
  input  logic [WAYS-1:0]              rd_valid,
  input  logic [WAYS-1:0]              rd_dirty,
  input  logic [WAYS*TAG_BITS-1:0]     rd_tags,
  output logic                         wr_en,
  output logic [SET_BITS-1:0]          wr_set,
  output logic [WAY_BITS-1:0]          wr_way,
  output logic                         wr_valid,
  output logic                         wr_dirty,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [TAG_BITS+SET_BITS-1:0] wb_addr,
  output logic [WAY_BITS-1:0]          wb_way,
  output logic                         rst_stall,
  output logic                         flush_stall,
  output logic [SET_BITS-1:0]          cur_set,
  output logic                         done
);

  typedef enum logic [2:0] {
    IDLE, RST_WALK, FL_READ, FL_LOAD, FL_SCAN, FL_WB, FL_NEXT
  } state_e;

  state_e                     state_q, state_d;
  logic                       rst_stall_q, rst_stall_d;
  logic                       flush_stall_q, flush_stall_d;
  logic                       flush_all_q, flush_all_d;
  logic                       rst_pend_q, rst_pend_d;
  logic [WAY_BITS-1:0]        way_q, way_d;
  logic [WAYS-1:0]            vld_buf_q, vld_buf_d;
  logic [WAYS-1:0]            dty_buf_q, dty_buf_d;
  logic [WAYS*TAG_BITS-1:0]   tag_buf_q, tag_buf_d;

  logic                       set_clr, set_inc, set_last, go_rst;
  logic                       way_last, cur_v, cur_d;
  logic [TAG_BITS-1:0]        cur_tag;

  llc_set_walker #(.SET_BITS(SET_BITS)) u_walker (
    .clk    (clk),
    .rst    (rst),
    .clr    (set_clr),
    .inc    (set_inc),
    .set_o  (cur_set),
    .last_o (set_last)
  );

  assign way_last = (way_q == WAY_BITS'(WAYS - 1));
  assign cur_v    = vld_buf_q[way_q];
  assign cur_d    = dty_buf_q[way_q];
  assign cur_tag  = tag_buf_q[way_q*TAG_BITS +: TAG_BITS];

  assign rst_wr_set  = cur_set;
  assign rd_set      = cur_set;
  assign wr_set      = cur_set;
  assign wr_way      = way_q;
  assign wb_way      = way_q;
  assign wb_addr     = {cur_tag, cur_set};
  assign rst_stall   = rst_stall_q;
  assign flush_stall = flush_stall_q;

  always_comb begin
    state_d       = state_q;
    rst_stall_d   = rst_stall_q;
    flush_stall_d = flush_stall_q;
    flush_all_d   = flush_all_q;
    rst_pend_d    = rst_pend_q;
    way_d         = way_q;
    vld_buf_d     = vld_buf_q;
    dty_buf_d     = dty_buf_q;
    tag_buf_d     = tag_buf_q;
    set_clr       = 1'b0;
    set_inc       = 1'b0;
    go_rst        = 1'b0;
    rst_wr_en     = 1'b0;
    rd_set_en     = 1'b0;
    wr_en         = 1'b0;
    wr_valid      = 1'b0;
    wr_dirty      = 1'b0;
    wb_valid      = 1'b0;
    done          = 1'b0;

    if (!rst) begin
      if (state_q != IDLE && state_q != RST_WALK) begin
        rst_pend_d = rst_pend_q | rst_req;
      end

      // A pending reset aborts the flush at once, except mid-writeback where the
      // handshake and its way write must finish first.
      if (rst_pend_q && state_q != FL_WB && state_q != RST_WALK) begin
        go_rst = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (rst_req) begin
              go_rst = 1'b1;
            end else if (flush_req && !rst_stall_q) begin
              flush_all_d   = flush_all;
              flush_stall_d = 1'b1;
              set_clr       = 1'b1;
              state_d       = FL_READ;
            end
          end
          RST_WALK: begin
            rst_wr_en = 1'b1;
            if (rst_req) begin
              set_clr = 1'b1;
            end else if (set_last) begin
              set_clr     = 1'b1;
              rst_stall_d = 1'b0;
              done        = 1'b1;
              state_d     = IDLE;
            end else begin
              set_inc = 1'b1;
            end
          end
          FL_READ: begin
            rd_set_en = 1'b1;
            state_d   = FL_LOAD;
          end
          FL_LOAD: begin
            vld_buf_d = rd_valid;
            dty_buf_d = rd_dirty;
            tag_buf_d = rd_tags;
            way_d     = '0;
            state_d   = FL_SCAN;
          end
          FL_SCAN: begin
            if (cur_v && cur_d) begin
              state_d = FL_WB;
            end else begin
              wr_en = cur_v && flush_all_q;
              if (way_last) begin
                state_d = FL_NEXT;
              end else begin
                way_d = way_q + WAY_BITS'(1);
              end
            end
          end
          FL_WB: begin
            wb_valid = 1'b1;
            if (wb_ready) begin
              wr_en    = 1'b1;
              wr_valid = ~flush_all_q;
              if (rst_pend_q) begin
                go_rst = 1'b1;
              end else if (way_last) begin
                state_d = FL_NEXT;
              end else begin
                way_d   = way_q + WAY_BITS'(1);
                state_d = FL_SCAN;
              end
            end
          end
          FL_NEXT: begin
            if (set_last) begin
              flush_stall_d = 1'b0;
              done          = 1'b1;
              set_clr       = 1'b1;
              state_d       = IDLE;
            end else begin
              set_inc = 1'b1;
              state_d = FL_READ;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      if (go_rst) begin
        state_d       = RST_WALK;
        rst_stall_d   = 1'b1;
        flush_stall_d = 1'b0;
        rst_pend_d    = 1'b0;
        set_clr       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RST_WALK;
      rst_stall_q   <= 1'b1;
      flush_stall_q <= 1'b0;
      flush_all_q   <= 1'b0;
      rst_pend_q    <= 1'b0;
      way_q         <= '0;
    end else begin
      state_q       <= state_d;
      rst_stall_q   <= rst_stall_d;
      flush_stall_q <= flush_stall_d;
      flush_all_q   <= flush_all_d;
      rst_pend_q    <= rst_pend_d;
      way_q         <= way_d;
    end
  end

  // NOTE: the line-state buffers are pure data, always loaded in FL_LOAD before use, so they carry no reset.
  always_ff @(posedge clk) begin
    vld_buf_q <= vld_buf_d;
    dty_buf_q <= dty_buf_d;
    tag_buf_q <= tag_buf_d;
  end

endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// Self-checking bench for llc_rst_flush_seq: expected per-cycle traces are generated from
// the walk rules against a model of the cache state array, then replayed and compared.
module tb_llc_rst_flush_seq;

  localparam int SB   = 2;
  localparam int SETS = 4;
  localparam int WY   = 4;
  localparam int TB   = 8;

  logic          clk = 1'b0;
  logic          rst, rst_req, flush_req, flush_all, wb_ready;
  logic          rst_wr_en, rd_set_en, wr_en, wr_valid, wr_dirty, wb_valid;
  logic          rst_stall, flush_stall, done;
  logic [SB-1:0] rst_wr_set, rd_set, wr_set, cur_set;
  logic [1:0]    wr_way, wb_way;
  logic [WY-1:0] rd_valid, rd_dirty;
  logic [WY*TB-1:0] rd_tags;
  logic [TB+SB-1:0] wb_addr;

  llc_rst_flush_seq #(.SET_BITS(SB), .WAYS(WY), .TAG_BITS(TB)) dut (
    .clk(clk), .rst(rst), .rst_req(rst_req), .flush_req(flush_req), .flush_all(flush_all),
    .rst_wr_en(rst_wr_en), .rst_wr_set(rst_wr_set), .rd_set_en(rd_set_en), .rd_set(rd_set),
    .rd_valid(rd_valid), .rd_dirty(rd_dirty), .rd_tags(rd_tags),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_valid(wr_valid), .wr_dirty(wr_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_way(wb_way),
    .rst_stall(rst_stall), .flush_stall(flush_stall), .cur_set(cur_set), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, rst_req, flush_req, flush_all, wb_ready;
    logic rst_wr_en; logic [1:0] rst_wr_set;
    logic rd_en; logic [1:0] rd_set;
    logic wr_en; logic [1:0] wr_set; logic [1:0] wr_way; logic wr_valid, wr_dirty;
    logic wb_valid; logic [9:0] wb_addr; logic [1:0] wb_way;
    logic rst_stall, flush_stall; logic [1:0] cur_set; logic done;
  } rec_t;

  rec_t q[$];

  // Cache state array seen by the DUT (updated by its writes) and the expected state.
  logic ram_v [SETS][WY];
  logic ram_d [SETS][WY];
  logic [TB-1:0] ram_t [SETS][WY];
  logic mdl_v [SETS][WY];
  logic mdl_d [SETS][WY];
  logic [TB-1:0] mdl_t [SETS][WY];

  int n_checks = 0, n_err = 0, cyc = 0;
  int n_rst_wr, n_done, n_wr, n_rd, n_fstall, n_wb55, n_wr_inv12, n_wr_cln12;
  logic [7:0] rst_seq;
  logic rd_pend = 1'b0;
  logic [1:0] rd_pend_set = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    n_rst_wr = 0; n_done = 0; n_wr = 0; n_rd = 0; n_fstall = 0;
    n_wb55 = 0; n_wr_inv12 = 0; n_wr_cln12 = 0; rst_seq = '0;
  endtask

  function automatic rec_t idle_rec();
    rec_t r = '{default: '0};
    r.wb_ready  = 1'($urandom);
    r.flush_all = 1'($urandom);
    return r;
  endfunction

  function automatic logic freq(input int mode);
    return (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
  endfunction

  function automatic rec_t fl_rec(input int s, input int fmode);
    rec_t r = idle_rec();
    r.flush_stall = 1'b1;
    r.cur_set     = 2'(s);
    r.flush_req   = freq(fmode);
    return r;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back(idle_rec());
  endtask

  task automatic push_walk(input int fmode);
    rec_t r;
    for (int i = 0; i < SETS; i++) begin
      r = idle_rec();
      r.flush_req  = freq(fmode);
      r.rst_wr_en  = 1'b1;
      r.rst_wr_set = 2'(i);
      r.rst_stall  = 1'b1;
      r.cur_set    = 2'(i);
      r.done       = (i == SETS - 1);
      q.push_back(r);
    end
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WY; w++) begin
        mdl_v[s][w] = 1'b0;
        mdl_d[s][w] = 1'b0;
      end
  endtask

  task automatic push_rst();
    rec_t r;
    for (int i = 0; i < 2; i++) begin
      r = idle_rec();
      r.rst = 1'b1;
      q.push_back(r);
    end
    push_walk(1);
  endtask

  task automatic push_rst_req(input bit with_flush);
    rec_t r = idle_rec();
    r.rst_req   = 1'b1;
    r.flush_req = with_flush;
    q.push_back(r);
    push_walk(with_flush ? 2 : 1);
  endtask

  // abort_sel: -1 no abort, -2 random point, -3 first cycle a writeback is waiting, >=0 index.
  task automatic push_flush(input bit fa, input int stall_fix, input int abort_sel, input int fmode);
    rec_t t[$];
    rec_t r;
    int x, a, stall;
    r = idle_rec();
    r.flush_req = 1'b1;
    r.flush_all = fa;
    q.push_back(r);
    for (int s = 0; s < SETS; s++) begin
      r = fl_rec(s, fmode); r.rd_en = 1'b1; r.rd_set = 2'(s); t.push_back(r);
      r = fl_rec(s, fmode); t.push_back(r);
      for (int w = 0; w < WY; w++) begin
        r = fl_rec(s, fmode);
        if (mdl_v[s][w] && !mdl_d[s][w] && fa) begin
          r.wr_en = 1'b1; r.wr_set = 2'(s); r.wr_way = 2'(w);
        end
        t.push_back(r);
        if (mdl_v[s][w] && mdl_d[s][w]) begin
          stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
          for (int k = 0; k <= stall; k++) begin
            r = fl_rec(s, fmode);
            r.wb_valid = 1'b1;
            r.wb_addr  = {mdl_t[s][w], 2'(s)};
            r.wb_way   = 2'(w);
            r.wb_ready = (k == stall);
            if (k == stall) begin
              r.wr_en = 1'b1; r.wr_set = 2'(s); r.wr_way = 2'(w); r.wr_valid = !fa;
            end
            t.push_back(r);
          end
        end
      end
      r = fl_rec(s, fmode); r.done = (s == SETS - 1); t.push_back(r);
    end

    x = -1;
    if (abort_sel == -2) x = int'($urandom_range(0, t.size() - 1));
    else if (abort_sel == -3) begin
      for (int i = 0; i < t.size(); i++)
        if (x < 0 && t[i].wb_valid && !t[i].wb_ready) x = i;
    end else x = abort_sel;

    if (x < 0) begin
      foreach (t[i]) q.push_back(t[i]);
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WY; w++)
          if (mdl_v[s][w] && (mdl_d[s][w] || fa)) begin
            mdl_v[s][w] = mdl_d[s][w] && !fa;
            mdl_d[s][w] = 1'b0;
          end
    end else begin
      t[x].rst_req = 1'b1;
      if (t[x].wb_valid && !t[x].wb_ready) begin
        a = x;
        while (!t[a].wb_ready) a++;
        for (int i = 0; i <= a; i++) q.push_back(t[i]);
      end else begin
        for (int i = 0; i <= x; i++) q.push_back(t[i]);
        r = idle_rec();
        if (x + 1 < t.size()) begin
          r.flush_stall = 1'b1;
          r.cur_set     = t[x+1].cur_set;
        end
        q.push_back(r);
      end
      push_walk(1);
    end
  endtask

  task automatic fill_random();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WY; w++) begin
        ram_v[s][w] = 1'($urandom); ram_d[s][w] = 1'($urandom); ram_t[s][w] = 8'($urandom);
        mdl_v[s][w] = ram_v[s][w]; mdl_d[s][w] = ram_d[s][w]; mdl_t[s][w] = ram_t[s][w];
      end
  endtask

  task automatic fill_directed();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WY; w++) begin
        ram_v[s][w] = 1'b0; ram_d[s][w] = 1'b0; ram_t[s][w] = 8'(s * 16 + w);
      end
    ram_v[1][2] = 1'b1; ram_d[1][2] = 1'b1; ram_t[1][2] = 8'h15;
    ram_v[1][0] = 1'b1; ram_d[1][0] = 1'b0; ram_t[1][0] = 8'h33;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WY; w++) begin
        mdl_v[s][w] = ram_v[s][w]; mdl_d[s][w] = ram_d[s][w]; mdl_t[s][w] = ram_t[s][w];
      end
  endtask

  // Replays the queued trace: drive just after the edge, compare on the falling edge.
  task automatic run_queue();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      rst = r.rst; rst_req = r.rst_req; flush_req = r.flush_req;
      flush_all = r.flush_all; wb_ready = r.wb_ready;
      if (rd_pend) begin
        for (int w = 0; w < WY; w++) begin
          rd_valid[w] = ram_v[rd_pend_set][w];
          rd_dirty[w] = ram_d[rd_pend_set][w];
          rd_tags[w*TB +: TB] = ram_t[rd_pend_set][w];
        end
        rd_pend = 1'b0;
      end
      @(negedge clk);
      cyc++;
      check("rst_wr_en", rst_wr_en, r.rst_wr_en);
      check("rd_set_en", rd_set_en, r.rd_en);
      check("wr_en", wr_en, r.wr_en);
      check("wb_valid", wb_valid, r.wb_valid);
      check("done", done, r.done);
      if (!r.rst) begin
        check("rst_stall", rst_stall, r.rst_stall);
        check("flush_stall", flush_stall, r.flush_stall);
        check("cur_set", cur_set, r.cur_set);
        if (r.rst_wr_en) check("rst_wr_set", rst_wr_set, r.rst_wr_set);
        if (r.rd_en) check("rd_set", rd_set, r.rd_set);
        if (r.wr_en) begin
          check("wr_set", wr_set, r.wr_set);
          check("wr_way", wr_way, r.wr_way);
          check("wr_valid", wr_valid, r.wr_valid);
          check("wr_dirty", wr_dirty, r.wr_dirty);
        end
        if (r.wb_valid) begin
          check("wb_addr", wb_addr, r.wb_addr);
          check("wb_way", wb_way, r.wb_way);
        end
      end
      if (rd_set_en) begin rd_pend = 1'b1; rd_pend_set = rd_set; end
      if (wr_en) begin
        ram_v[wr_set][wr_way] = wr_valid;
        ram_d[wr_set][wr_way] = wr_dirty;
      end
      if (rst_wr_en)
        for (int w = 0; w < WY; w++) begin
          ram_v[rst_wr_set][w] = 1'b0;
          ram_d[rst_wr_set][w] = 1'b0;
        end
      if (rst_wr_en) begin n_rst_wr++; rst_seq = {rst_seq[5:0], rst_wr_set}; end
      if (done) n_done++;
      if (wr_en) n_wr++;
      if (rd_set_en) n_rd++;
      if (flush_stall) n_fstall++;
      if (wb_valid && wb_addr == 10'h055 && wb_way == 2'd2) n_wb55++;
      if (wr_en && wr_set == 2'd1 && wr_way == 2'd2 && !wr_valid && !wr_dirty) n_wr_inv12++;
      if (wr_en && wr_set == 2'd1 && wr_way == 2'd2 && wr_valid && !wr_dirty) n_wr_cln12++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    rst = 1'b1; rst_req = 1'b0; flush_req = 1'b0; flush_all = 1'b0; wb_ready = 1'b0;
    rd_valid = '0; rd_dirty = '0; rd_tags = '0;
    fill_random();

    // Reset walk: sets 0..3 on consecutive cycles, done with the last write.
    clr_stats();
    push_rst();
    push_idle(3);
    run_queue();
    check("p1 rst_wr_en count", n_rst_wr, 4);
    check("p1 rst_wr_set order", rst_seq, 8'h1B);
    check("p1 done count", n_done, 1);
    check("p1 rd count", n_rd, 0);

    // Dirty way writeback stalled 3 cycles, invalidating flush.
    fill_directed();
    clr_stats();
    push_flush(1'b1, 3, -1, 0);
    push_idle(2);
    run_queue();
    check("p2 wb_valid cycles at 0x55", n_wb55, 4);
    check("p2 invalidate of set1 way2", n_wr_inv12, 1);
    check("p2 wr_en count", n_wr, 2);
    check("p2 flush_stall cycles", n_fstall, 32);
    check("p2 done count", n_done, 1);

    // Same stimulus, clean-only flush: clean valid way gets no write.
    fill_directed();
    clr_stats();
    push_flush(1'b0, 3, -1, 0);
    push_idle(2);
    run_queue();
    check("p3 wb_valid cycles at 0x55", n_wb55, 4);
    check("p3 clean write of set1 way2", n_wr_cln12, 1);
    check("p3 wr_en count", n_wr, 1);
    check("p3 flush_stall cycles", n_fstall, 32);

    // Reset request while the writeback waits: handshake completes, then reset walk.
    fill_directed();
    clr_stats();
    push_flush(1'b1, 3, -3, 0);
    push_idle(2);
    run_queue();
    check("p4 wb_valid cycles at 0x55", n_wb55, 4);
    check("p4 wr_en count", n_wr, 2);
    check("p4 rst_wr_en count", n_rst_wr, 4);
    check("p4 done count", n_done, 1);

    // Reset beats a simultaneous flush; flush_req ignored during both walks.
    clr_stats();
    push_rst_req(1'b1);
    push_idle(2);
    push_flush(1'b1, 0, -1, 2);
    push_idle(2);
    run_queue();
    check("p5 rd_set_en count", n_rd, 4);
    check("p5 clean flush length", n_fstall, 28);
    check("p5 done count", n_done, 2);
    check("p5 wr_en count", n_wr, 0);

    // Randomized mix of flushes, aborted flushes and resets.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      if (op < 6) begin
        if ($urandom_range(0, 1) == 1) fill_random();
        push_flush(1'($urandom), -1, -1, 1);
      end else if (op < 8) begin
        fill_random();
        push_flush(1'($urandom), -1, -2, 1);
      end else if (op == 8) begin
        push_rst_req(1'b0);
      end else begin
        push_rst();
      end
      push_idle(int'($urandom_range(0, 3)));
      run_queue();
    end

    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WY; w++) begin
        check($sformatf("final valid s%0d w%0d", s, w), ram_v[s][w], mdl_v[s][w]);
        check($sformatf("final dirty s%0d w%0d", s, w), ram_d[s][w], mdl_d[s][w]);
      end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
